piso_serializer: RTL and testbench

// Parallel-in, serial-out shift register: the transmit side of the team's serial-in, parallel-out shift link.
// - Accepts an MSB-bit word through a valid/ready load handshake.
// - Shifts the word out one bit per enabled cycle, MSB-first or LSB-first.
// - Flags frame boundaries, and can stream words back-to-back with no idle gap.
// - A receiving shift register in right-shift mode reconstructs an LSB-first frame; in left-shift mode, an MSB-first frame.
//

---
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with valid/ready load.
// Streams MSB-bit words MSB- or LSB-first, gapless when reloaded.
module piso_serializer #(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] load_data,
  input  logic           direction,
  input  logic           en,
  output logic           sout,
  output logic           sout_valid,
  output logic           frame_start,
  output logic           done
);

  localparam int CW = (MSB > 2) ? $clog2(MSB) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(MSB - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e         state_q, state_d;
  logic [MSB-1:0] sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           done_q, done_d;
  logic           fire;
  logic           consume;

  // Output decode from registered state; load_ready also looks at en
  always_comb begin
    sout_valid  = (state_q == SHIFT);
    sout        = 1'b0;
    frame_start = 1'b0;
    load_ready  = 1'b0;
    if (state_q == SHIFT) begin
      sout        = dir_q ? sreg_q[0] : sreg_q[MSB-1];
      frame_start = (cnt_q == CNT_TOP);
      load_ready  = (cnt_q == '0) && en;
    end else begin
      load_ready  = 1'b1;
    end
    done = done_q;
  end

  // Next-state: consume a bit, then let a same-edge load override
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    fire    = load_valid && load_ready;
    consume = (state_q == SHIFT) && en;
    case (state_q)
      SHIFT: begin
        if (consume) begin
          if (dir_q) begin
            sreg_d = {1'b0, sreg_q[MSB-1:1]};
          end else begin
            sreg_d = {sreg_q[MSB-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (fire) begin
      sreg_d  = load_data;
      dir_d   = direction;
      cnt_d   = CNT_TOP;
      state_d = SHIFT;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed frames then random traffic,
// checked each cycle against a queue-of-pending-bits model.
module tb_piso_serializer;

  localparam int MSB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_valid;
  logic           load_ready;
  logic [MSB-1:0] load_data;
  logic           direction;
  logic           en;
  logic           sout;
  logic           sout_valid;
  logic           frame_start;
  logic           done;

  int errors = 0;
  int checks = 0;

  // model: bits still to be emitted, in emission order
  bit m_q[$];
  bit m_done = 1'b0;

  // observed frame bits, for directed sequence checks
  logic [31:0]    obs;
  int             nobs;
  logic [MSB-1:0] rx;

  piso_serializer #(.MSB(MSB)) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .direction(direction),
    .en(en),
    .sout(sout),
    .sout_valid(sout_valid),
    .frame_start(frame_start),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h t=%0t",
             tag, o, e, $time);
    end
  endtask

  task automatic clr_obs();
    obs  = '0;
    nobs = 0;
    rx   = '0;
  endtask

  // one clock cycle: drive, compare against model, clock, update model
  task automatic step(input logic r, input logic lv,
                      input logic [MSB-1:0] d, input logic dr,
                      input logic e);
    bit m_valid, m_sout, m_fs, m_rdy, cons, fire;
    rst = r;
    load_valid = lv;
    load_data = d;
    direction = dr;
    en = e;
    #1;
    m_valid = (m_q.size() > 0);
    m_sout  = m_valid ? m_q[0] : 1'b0;
    m_fs    = (m_q.size() == MSB);
    m_rdy   = (m_q.size() == 0) || (m_q.size() == 1 && e);
    chk("sout_valid", 32'(sout_valid), 32'(m_valid));
    chk("sout", 32'(sout), 32'(m_sout));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("done", 32'(done), 32'(m_done));
    chk("load_ready", 32'(load_ready), 32'(m_rdy));
    if (sout_valid === 1'b1) begin
      obs = {obs[30:0], sout};
      nobs++;
      rx = {sout, rx[MSB-1:1]};
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      fire   = lv && m_rdy;
      cons   = (m_q.size() > 0) && e;
      m_done = cons && (m_q.size() == 1);
      if (cons) void'(m_q.pop_front());
      if (fire) begin
        for (int i = 0; i < MSB; i++) begin
          m_q.push_back(dr ? d[i] : d[MSB-1-i]);
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    direction = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    m_q.delete();
    m_done = 1'b0;

    // reset state, en in IDLE is ignored
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

    // 1: MSB-first 1011
    clr_obs();
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t1_bits", obs, 32'b1011);
    chk("t1_len", 32'(nobs), 32'd4);

    // 2: LSB-first 1011, right-shift receiver rebuilds word
    clr_obs();
    step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t2_bits", obs, 32'b1101);
    chk("t2_rx", 32'(rx), 32'b1011);

    // 3: stall two cycles after bit 2
    clr_obs();
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t3_bits", obs, 32'b100011);
    chk("t3_len", 32'(nobs), 32'd6);

    // 4: back-to-back words with load_valid held
    clr_obs();
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t4_bits", obs, 32'b10110110);
    chk("t4_len", 32'(nobs), 32'd8);

    // 5: reset during bit 2 aborts the frame
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

    // 6: load attempt mid-frame is refused
    clr_obs();
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t6_bits", obs, 32'b1011);
    chk("t6_len", 32'(nobs), 32'd4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           1'($urandom),
           MSB'($urandom),
           1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
